// File: rtl/aixh_mxc_upper_ptile_cell_drain.sv
// Drain of one MxConv upper p-tile cell: snapshots the NUM_PE signed
// accumulators, requantizes each one (arithmetic right shift with signed
// saturation to OUT_BITS) and streams the words out over valid/ready.
// Optional build macro: AIXH_MXC_DRAIN_ROUND_EN enables round-half-up before
// the shift. Without it the shift truncates toward -inf.
module aixh_mxc_upper_ptile_cell_drain #(
  parameter int NUM_PE     = 8,
  parameter int ACCUM_BITS = 48,
  parameter int OUT_BITS   = 32,
  parameter int IDX_BITS   = $clog2(NUM_PE)
) (
  input  logic                           aixh_core_clk2x,
  input  logic                           aixh_core_rst2x,
  input  logic                           drain_start,
  input  logic [4:0]                     drain_rshift,
  input  logic [NUM_PE*ACCUM_BITS-1:0]   izdata,
  output logic                           drain_busy,
  output logic                           drain_done,
  output logic                           o_valid,
  input  logic                           o_ready,
  output logic [OUT_BITS-1:0]            o_data,
  output logic [IDX_BITS-1:0]            o_idx,
  output logic                           o_last
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_PE - 1);
`ifdef AIXH_MXC_DRAIN_ROUND_EN
  localparam int RW = ACCUM_BITS + 1;  // one guard bit so the rounding add cannot overflow
`else
  localparam int RW = ACCUM_BITS;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t                        state, state_nxt;
  logic [IDX_BITS-1:0]           idx, idx_nxt;
  logic [4:0]                    rshift_p0;
  logic signed [ACCUM_BITS-1:0]  snap_p0 [NUM_PE];
  logic                          accept, load_word, busy_nxt, done_nxt, valid_nxt;

  // Shift right with optional round-half-up, result kept at full width.
  function automatic logic signed [RW-1:0] round_shift(
    input logic signed [ACCUM_BITS-1:0] v,
    input logic [4:0]                   sh
  );
    logic signed [RW-1:0] r;
`ifdef AIXH_MXC_DRAIN_ROUND_EN
    logic [RW-1:0] rnd;
    rnd = (sh == 5'd0) ? '0 : ({{(RW-1){1'b0}}, 1'b1} << (sh - 5'd1));
    r   = $signed({v[ACCUM_BITS-1], v}) + $signed(rnd);
`else
    r   = v;
`endif
    return r >>> sh;
  endfunction

  // Clamp a full-width signed value into the OUT_BITS signed range.
  function automatic logic [OUT_BITS-1:0] saturate(input logic signed [RW-1:0] s);
    if (!s[RW-1] && (|s[RW-2:OUT_BITS-1]))
      return {1'b0, {(OUT_BITS-1){1'b1}}};
    else if (s[RW-1] && !(&s[RW-2:OUT_BITS-1]))
      return {1'b1, {(OUT_BITS-1){1'b0}}};
    else
      return s[OUT_BITS-1:0];
  endfunction

  // Next-state and control decode; a handshake on a non-last word loads the
  // following word in the same cycle so streaming runs at one word per clock.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    accept    = 1'b0;
    load_word = 1'b0;
    busy_nxt  = drain_busy;
    done_nxt  = 1'b0;
    valid_nxt = o_valid;
    case (state)
      IDLE: begin
        if (drain_start) begin
          accept    = 1'b1;
          idx_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load_word = 1'b1;
        valid_nxt = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        if (o_valid && o_ready) begin
          if (o_last) begin
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            idx_nxt   = idx + 1'b1;
            load_word = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge aixh_core_clk2x) begin
    if (aixh_core_rst2x) begin
      state      <= IDLE;
      idx        <= '0;
      drain_busy <= 1'b0;
      drain_done <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_idx      <= '0;
      o_last     <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      drain_busy <= busy_nxt;
      drain_done <= done_nxt;
      o_valid    <= valid_nxt;
      if (load_word) begin
        o_data <= saturate(round_shift(snap_p0[idx_nxt], rshift_p0));
        o_idx  <= idx_nxt;
        o_last <= (idx_nxt == LAST_IDX);
      end
    end
  end

  // ---- stage p0: accumulator snapshot, taken only in the accept cycle ----
  always_ff @(posedge aixh_core_clk2x) begin
    if (accept) begin
      rshift_p0 <= drain_rshift;
      for (int k = 0; k < NUM_PE; k++)
        snap_p0[k] <= izdata[k*ACCUM_BITS +: ACCUM_BITS];
    end
  end

endmodule

// File: tb/tb_aixh_mxc_upper_ptile_cell_drain.sv
// Scoreboard bench for aixh_mxc_upper_ptile_cell_drain.
// Build with +define+AIXH_MXC_DRAIN_ROUND_EN to exercise the rounding build.
module tb_aixh_mxc_upper_ptile_cell_drain;

  localparam int NUM_PE = 8;
  localparam int AB     = 48;
  localparam int OB     = 32;
  localparam int IB     = 3;
`ifdef AIXH_MXC_DRAIN_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 drain_start = 1'b0;
  logic [4:0]           drain_rshift = '0;
  logic [NUM_PE*AB-1:0] izdata = '0;
  logic                 drain_busy, drain_done, o_valid, o_last;
  logic                 o_ready = 1'b1;
  logic [OB-1:0]        o_data;
  logic [IB-1:0]        o_idx;

  typedef struct {
    logic [OB-1:0] data;
    int            idx;
    bit            last;
  } exp_t;

  exp_t   q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  longint pe [NUM_PE];
  int     stall_idx = -1;
  int     stall_left = 0;
  bit     stalled_once = 1'b0;

  aixh_mxc_upper_ptile_cell_drain #(
    .NUM_PE(NUM_PE), .ACCUM_BITS(AB), .OUT_BITS(OB), .IDX_BITS(IB)
  ) dut (
    .aixh_core_clk2x(clk),
    .aixh_core_rst2x(rst),
    .drain_start(drain_start),
    .drain_rshift(drain_rshift),
    .izdata(izdata),
    .drain_busy(drain_busy),
    .drain_done(drain_done),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .o_data(o_data),
    .o_idx(o_idx),
    .o_last(o_last)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference requantizer in 64-bit arithmetic.
  function automatic logic [OB-1:0] model(input longint v, input int sh);
    longint r, s;
    r = v;
    if (ROUND && sh > 0) r = r + (64'sd1 <<< (sh - 1));
    s = r >>> sh;
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  task automatic set_iz();
    for (int k = 0; k < NUM_PE; k++) izdata[k*AB +: AB] = pe[k][AB-1:0];
  endtask

  task automatic push_exp(input int k, input logic [OB-1:0] d);
    exp_t e;
    e.data = d;
    e.idx  = k;
    e.last = (k == NUM_PE - 1);
    q.push_back(e);
  endtask

  task automatic push_model(input int from, input int sh);
    for (int k = from; k < NUM_PE; k++) push_exp(k, model(pe[k], sh));
  endtask

  // Returns just after the edge that samples drain_start.
  task automatic pulse_start(input int sh);
    @(posedge clk); #1;
    drain_start  = 1'b1;
    drain_rshift = 5'(sh);
    @(posedge clk); #1;
    drain_start  = 1'b0;
  endtask

  // Counts cycles from the one after acceptance until drain_done is seen.
  task automatic wait_done(output int n, output int first_v, output int busy_drop);
    n = 0; first_v = -1; busy_drop = 0;
    forever begin
      @(negedge clk);
      if (drain_done) break;
      if (o_valid && first_v < 0) first_v = n;
      if (!drain_busy) busy_drop++;
      if (n > 200) begin
        check_val("done_timeout", 64'(n), 64'(NUM_PE + 1));
        break;
      end
      @(posedge clk);
      n++;
    end
  endtask

  // Backpressure driver: stalls the word at stall_idx once for 5 cycles.
  always @(posedge clk) begin
    #1;
    if (!stalled_once && o_valid && stall_idx >= 0 && int'(o_idx) == stall_idx) begin
      stalled_once = 1'b1;
      stall_left   = 5;
    end
    if (stall_left > 0) begin
      o_ready = 1'b0;
      stall_left--;
    end else begin
      o_ready = 1'b1;
    end
  end

  // Output monitor: scoreboard pop on handshake, hold check under backpressure.
  logic          held_v = 1'b0;
  logic [OB-1:0] held_d;
  logic [IB-1:0] held_i;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (held_v) begin
        check_val("hold_valid", 64'(o_valid), 64'd1);
        check_val("hold_data", 64'(o_data), 64'(held_d));
        check_val("hold_idx", 64'(o_idx), 64'(held_i));
      end
      if (o_valid && o_ready) begin
        if (q.size() == 0) begin
          check_val("unexpected_word", 64'(o_idx), 64'hFFFF);
        end else begin
          e = q.pop_front();
          check_val("data", 64'(o_data), 64'(e.data));
          check_val("idx", 64'(o_idx), 64'(e.idx));
          check_val("last", 64'(o_last), 64'(e.last));
        end
      end
    end
    held_v = !rst && o_valid && !o_ready;
    held_d = o_data;
    held_i = o_idx;
  end

  initial begin
    int n, fv, bd;
    bit seen;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_valid", 64'(o_valid), 64'd0);
    check_val("rst_busy", 64'(drain_busy), 64'd0);
    check_val("rst_done", 64'(drain_done), 64'd0);
    check_val("rst_data", 64'(o_data), 64'd0);
    check_val("rst_idx", 64'(o_idx), 64'd0);
    check_val("rst_last", 64'(o_last), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic stream: PE k = k*100, no shift
    for (int k = 0; k < NUM_PE; k++) pe[k] = longint'(k * 100);
    set_iz();
    for (int k = 0; k < NUM_PE; k++) push_exp(k, 32'(k * 100));
    pulse_start(0);
    wait_done(n, fv, bd);
    check_val("basic_first_valid", 64'(fv), 64'd1);
    check_val("basic_done_lat", 64'(n), 64'(NUM_PE + 1));
    check_val("basic_busy_gap", 64'(bd), 64'd0);

    // Start in the drain_done cycle is accepted: rounding pattern
    pe[0] = 3; pe[1] = -3; pe[2] = 5;
    for (int k = 3; k < NUM_PE; k++) pe[k] = 0;
    set_iz();
    if (ROUND) begin
      push_exp(0, 32'd2); push_exp(1, 32'hFFFF_FFFF); push_exp(2, 32'd3);
    end else begin
      push_exp(0, 32'd1); push_exp(1, 32'hFFFF_FFFE); push_exp(2, 32'd2);
    end
    push_model(3, 1);
    drain_start = 1'b1; drain_rshift = 5'd1;
    @(posedge clk); #1 drain_start = 1'b0;
    wait_done(n, fv, bd);
    check_val("round_done_lat", 64'(n), 64'(NUM_PE + 1));

    // Saturation, no shift
    pe[0] = 64'sd1 <<< 40; pe[1] = -(64'sd1 <<< 40); pe[2] = 64'sd2147483647;
    set_iz();
    push_exp(0, 32'h7FFF_FFFF); push_exp(1, 32'h8000_0000); push_exp(2, 32'h7FFF_FFFF);
    push_model(3, 0);
    pulse_start(0);
    wait_done(n, fv, bd);

    // Saturation boundary with shift 9
    pe[2] = 64'sd1 <<< 39;
    pe[3] = -64'sd7; pe[4] = 64'sd1000000; pe[5] = -(64'sd1 <<< 45);
    set_iz();
    push_exp(0, 32'h7FFF_FFFF); push_exp(1, 32'h8000_0000); push_exp(2, 32'h4000_0000);
    push_model(3, 9);
    pulse_start(9);
    wait_done(n, fv, bd);

    // Backpressure on idx 3, random data and shift
    for (int k = 0; k < NUM_PE; k++)
      pe[k] = longint'({$urandom(), $urandom()}) >>> (16 + k);
    set_iz();
    stall_idx = 3;
    push_model(0, 13);
    pulse_start(13);
    wait_done(n, fv, bd);
    check_val("bp_done_lat", 64'(n), 64'(NUM_PE + 1 + 5));
    check_val("bp_busy_gap", 64'(bd), 64'd0);

    // Snapshot isolation and ignored start while busy
    for (int k = 0; k < NUM_PE; k++) pe[k] = longint'(k) * 64'sd123457 - 64'sd400000;
    set_iz();
    push_model(0, 4);
    pulse_start(4);
    @(posedge clk); #1;
    izdata       = {NUM_PE{48'h7FFF_0000_1234}};
    drain_start  = 1'b1;
    drain_rshift = 5'd0;
    @(posedge clk); #1 drain_start = 1'b0;
    wait_done(n, fv, bd);
    check_val("snap_done_lat", 64'(n), 64'(NUM_PE - 1));
    check_val("snap_busy_gap", 64'(bd), 64'd0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (drain_done || o_valid || drain_busy) seen = 1'b1;
    end
    check_val("snap_no_second_drain", 64'(seen), 64'd0);

    // Reset after the idx 2 handshake
    for (int k = 0; k < NUM_PE; k++) pe[k] = longint'(k + 1) * 64'sd999;
    set_iz();
    push_model(0, 2);
    pulse_start(2);
    n = 0;
    forever begin
      @(negedge clk);
      if (o_valid && o_ready && o_idx == 3'd2) break;
      n++;
      if (n > 50) begin
        check_val("idx2_timeout", 64'(n), 64'd0);
        break;
      end
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("mid_rst_valid", 64'(o_valid), 64'd0);
    check_val("mid_rst_busy", 64'(drain_busy), 64'd0);
    check_val("mid_rst_done", 64'(drain_done), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    q.delete();
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (drain_done || o_valid) seen = 1'b1;
    end
    check_val("mid_rst_quiet", 64'(seen), 64'd0);
    push_model(0, 2);
    pulse_start(2);
    wait_done(n, fv, bd);
    check_val("restart_done_lat", 64'(n), 64'(NUM_PE + 1));

    repeat (3) @(posedge clk);
    check_val("sb_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
